// File: rtl/seq_detect_scheduler_if.sv
// Request/response bundle between NREQ parallel producers and the shared
// "001" detector scheduler.
//   master : requester side - drives req_valid/req_data/rsp_ready
//   slave  : scheduler side - drives req_ready and the rsp_* result fields
// Parameters NREQ/WIDTH/CNT_W must match the seq_detect_scheduler instance.
interface seq_detect_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [CNT_W-1:0]      rsp_count;
    logic                  rsp_hit;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_hit
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_hit
    );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Shares one serial "001" sequence detector between NREQ requesters.
// A round-robin arbiter accepts one WIDTH-bit word, shifts it MSB-first
// through the detector (one bit per clock), counts the matches and holds the
// result on the response channel until it is consumed.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   bus        seq_detect_scheduler_if.slave (req_valid/req_data/req_ready,
//              rsp_valid/rsp_ready/rsp_id/rsp_count/rsp_hit)
//   busy       FSM not in IDLE (registered)
//   det_state  detector state for debug (registered)
//   total_jobs, total_hits  only when SEQ_SCHED_STATS_EN is defined:
//              handshake and match totals, wrapping modulo 2^16
module seq_detect_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_detect_scheduler_if.slave bus,
    output logic                 busy,
    output logic [1:0]           det_state
`ifdef SEQ_SCHED_STATS_EN
    ,
    output logic [15:0]          total_jobs,
    output logic [15:0]          total_hits
`endif
);
    localparam int          ID_W   = $clog2(NREQ);
    localparam int          BIT_W  = $clog2(WIDTH);
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    typedef enum logic [1:0] {DS0 = 2'b00, DS1 = 2'b01, DS2 = 2'b10} det_t;

    state_t            state_q, state_d;
    det_t              det_q, det_d;
    logic [ID_W-1:0]   rr_q, id_q, gnt_idx, cand_idx;
    logic [WIDTH-1:0]  data_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CNT_W-1:0]  count_q;
    logic              hit_q, rsp_valid_q, busy_q;
    logic              gnt_valid, accept, shift_bit, match, last_bit, rsp_fire;
    int unsigned       cand;

    // Round robin: scan starting just after the last granted index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            cand     = (32'(rr_q) + k) % NREQ_U;
            cand_idx = ID_W'(cand);
            if (!gnt_valid && bus.req_valid[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Gated by reset so a grant strobe is never shown for a cycle that
    // the synchronous reset throws away.
    assign accept = (state_q == IDLE) && gnt_valid && !reset;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // The latched word is shifted left, so the current bit is always the MSB.
    assign shift_bit = data_q[WIDTH-1];
    assign last_bit  = (bit_q == BIT_W'(WIDTH - 1));
    assign rsp_fire  = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        det_d = det_q;
        match = 1'b0;
        case (det_q)
            DS0:     det_d = shift_bit ? DS0 : DS1;
            DS1:     det_d = shift_bit ? DS0 : DS2;
            DS2: begin
                det_d = shift_bit ? DS0 : DS2;
                match = shift_bit;
            end
            default: det_d = DS0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            det_q       <= DS0;
            rr_q        <= ID_W'(NREQ - 1);
            id_q        <= '0;
            data_q      <= '0;
            bit_q       <= '0;
            count_q     <= '0;
            hit_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SEQ_SCHED_STATS_EN
            total_jobs  <= '0;
            total_hits  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= bus.req_data[gnt_idx*WIDTH +: WIDTH];
                        id_q    <= gnt_idx;
                        rr_q    <= gnt_idx;
                        count_q <= '0;
                        hit_q   <= 1'b0;
                        bit_q   <= '0;
                        det_q   <= DS0;
                    end
                end
                SHIFT: begin
                    data_q <= data_q << 1;
                    bit_q  <= bit_q + BIT_W'(1);
                    det_q  <= det_d;
                    if (match) begin
                        count_q <= count_q + CNT_W'(1);
                        hit_q   <= 1'b1;
                    end
                end
                RESP: begin
`ifdef SEQ_SCHED_STATS_EN
                    if (rsp_fire) begin
                        total_jobs <= total_jobs + 16'd1;
                        total_hits <= total_hits + 16'(count_q);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_count = count_q;
    assign bus.rsp_hit   = hit_q;
    assign busy          = busy_q;
    assign det_state     = det_q;
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: expected results are pushed to a
// scoreboard at grant time and popped when the response appears.
module tb_seq_detect_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [1:0]  det_state;
`ifdef SEQ_SCHED_STATS_EN
    logic [15:0] total_jobs, total_hits;
`endif
    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [7:0]  rr_words[4];

    seq_detect_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_detect_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .det_state (det_state)
`ifdef SEQ_SCHED_STATS_EN
        ,
        .total_jobs(total_jobs),
        .total_hits(total_hits)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts "001" windows reading the word MSB first.
    function automatic int count001(input logic [7:0] w);
        int c = 0;
        for (int i = 0; i <= 5; i++)
            if (w[i+2] == 1'b0 && w[i+1] == 1'b0 && w[i] == 1'b1) c++;
        return c;
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    // Waits for the grant, checks it, records the expectation, steps past
    // the accept edge and checks the strobe was a single cycle.
    task automatic wait_grant(input int exp_id, input logic [7:0] w);
        int n = 0;
        #1;
        while (bus.req_ready == '0 && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("grant", 32'(bus.req_ready), 32'(1 << exp_id));
        sb.push_back('{exp_id, count001(w)});
        tick();
        chk("ready_pulse", 32'(bus.req_ready), 32'd0);
    endtask

    // Called one cycle after the accept edge; hold>0 stalls rsp_ready.
    task automatic collect(input int hold);
        int   n = 1;
        exp_t e;
        bus.rsp_ready = (hold == 0);
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(WIDTH + 1));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            bus.req_valid[2] = 1'b1;
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_count", 32'(bus.rsp_count), 32'(e.cnt));
            chk("hold_id", 32'(bus.rsp_id), 32'(e.id));
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            tick();
        end
        bus.req_valid[2] = (hold == 0) ? bus.req_valid[2] : 1'b0;
        bus.rsp_ready = 1'b1;
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_count", 32'(bus.rsp_count), 32'(e.cnt));
        chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.cnt != 0));
        tick();
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic run_job(input int id, input logic [7:0] w, input int hold);
        bus.req_data[id*WIDTH +: WIDTH] = w;
        bus.req_valid[id] = 1'b1;
        wait_grant(id, w);
        // Late drop and data change must not disturb the latched job.
        bus.req_valid[id] = 1'b0;
        bus.req_data[id*WIDTH +: WIDTH] = ~w;
        collect(hold);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        rr_words[0] = 8'h24;
        rr_words[1] = 8'hFF;
        rr_words[2] = 8'h11;
        rr_words[3] = 8'h49;

        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_det", 32'(det_state), 32'd0);
        chk("rst_count", 32'(bus.rsp_count), 32'd0);
        chk("rst_hit", 32'(bus.rsp_hit), 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);

        run_job(0, 8'b0010_0100, 0);
        run_job(1, 8'hFF, 0);
        run_job(2, 8'h00, 0);
        run_job(3, 8'b0001_0001, 0);
        run_job(1, 8'b0010_0100, 5);

        // Round robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = rr_words[i];
        bus.req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(i % NREQ, rr_words[i % NREQ]);
            if (i == 4) bus.req_valid = '0;
            collect(0);
        end

        // Reset in the 4th SHIFT cycle discards the job.
        run_job(0, 8'h24, 0);
        bus.req_data[3*WIDTH +: WIDTH] = 8'h11;
        bus.req_valid[3] = 1'b1;
        wait_grant(3, 8'h11);
        bus.req_valid[3] = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_det", 32'(det_state), 32'd0);
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = rr_words[i];
        bus.req_valid = '1;
        wait_grant(0, rr_words[0]);
        bus.req_valid = '0;
        collect(0);

        // Three jobs with counts 2, 0, 2 from a clean reset.
        do_reset();
        run_job(0, 8'h24, 0);
        run_job(1, 8'hFF, 0);
        run_job(2, 8'h11, 0);
`ifdef SEQ_SCHED_STATS_EN
        chk("total_jobs", 32'(total_jobs), 32'd3);
        chk("total_hits", 32'(total_hits), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
